// File: rtl/video_io_pkg.sv
// rtl/video_io_pkg.sv - shared defaults, sideband struct and serializer state for the pad mux
package video_io_pkg;

  localparam int DEF_PIX_W = 24;
  localparam int DEF_PAD_W = 12;
  localparam int DEF_DEPTH = 4;

  typedef struct packed {
    logic vsync;
    logic hsync;
    logic de;
  } sideband_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/pad_mux_fifo.sv
// rtl/pad_mux_fifo.sv - synchronous pixel+sideband FIFO with head-entry view
module pad_mux_fifo #(
  parameter int W     = 27,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [W-1:0]             head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: reads are gated by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/video_pad_mux_tx.sv
// rtl/video_pad_mux_tx.sv - pixel-to-pad serializer, MSB slice first; VIDEO_PAD_PARITY_EN adds O_PAD_PARITY
module video_pad_mux_tx
  import video_io_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W,
  parameter int PAD_W = DEF_PAD_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             I_CORE_CLK,
  input  logic             I_RST,
  input  logic             I_PIX_VALID,
  output logic             O_PIX_READY,
  input  logic [PIX_W-1:0] I_PIX_DATA,
  input  logic             I_VSYNC,
  input  logic             I_HSYNC,
  input  logic             I_DE,
  input  logic             I_CLR_ERR,
  output logic [PAD_W-1:0] O_PAD_DATA,
  output logic             O_BEAT0,
  output logic             O_VSYNC,
  output logic             O_HSYNC,
  output logic             O_DE,
  output logic             O_UNDERFLOW
`ifdef VIDEO_PAD_PARITY_EN
  ,
  output logic             O_PAD_PARITY
`endif
);

  localparam int BEATS = PIX_W / PAD_W;
  localparam int BW    = $clog2(BEATS);
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int EW    = PIX_W + 3;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  ser_state_t       state_q, state_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [PIX_W-1:0] sh_q, sh_d;
  logic [PAD_W-1:0] pad_d;
  logic             beat0_d, under_d, load, push, pop;
  sideband_t        sb_q, sb_d, head_sb;
  logic [PIX_W-1:0] head_pix;
  logic [EW-1:0]    head;
  logic [CW-1:0]    count, count_d;
  logic             full, empty;

  assign push    = I_PIX_VALID && O_PIX_READY && !full;
  assign pop     = load;
  assign count_d = count + CW'(push) - CW'(pop);

  pad_mux_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (I_CORE_CLK),
    .rst   (I_RST),
    .push  (push),
    .wdata ({I_VSYNC, I_HSYNC, I_DE, I_PIX_DATA}),
    .pop   (pop),
    .count (count),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign head_sb  = sideband_t'(head[EW-1 -: 3]);
  assign head_pix = head[PIX_W-1:0];

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    sh_d    = sh_q;
    pad_d   = '0;
    beat0_d = 1'b0;
    sb_d    = sb_q;
    load    = 1'b0;
    under_d = I_CLR_ERR ? 1'b0 : O_UNDERFLOW;
    case (state_q)
      IDLE: load = !empty;
      SHIFT: begin
        if (beat_q != LAST) begin
          beat_d = beat_q + BW'(1);
          pad_d  = sh_q[PIX_W-1 -: PAD_W];
          sh_d   = sh_q << PAD_W;
        end else if (!empty) begin
          load = 1'b1;
        end else begin
          state_d = IDLE;
          // Running dry inside active video is the error; set beats clear.
          if (sb_q.de) under_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = SHIFT;
      beat_d  = '0;
      pad_d   = head_pix[PIX_W-1 -: PAD_W];
      sh_d    = head_pix << PAD_W;
      beat0_d = 1'b1;
      sb_d    = head_sb;
    end else if (state_d == IDLE) begin
      sb_d.de = 1'b0;
    end
  end

  always_ff @(posedge I_CORE_CLK or posedge I_RST) begin
    if (I_RST) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      sh_q        <= '0;
      sb_q        <= '0;
      O_PAD_DATA  <= '0;
      O_BEAT0     <= 1'b0;
      O_UNDERFLOW <= 1'b0;
      O_PIX_READY <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      sh_q        <= sh_d;
      sb_q        <= sb_d;
      O_PAD_DATA  <= pad_d;
      O_BEAT0     <= beat0_d;
      O_UNDERFLOW <= under_d;
      O_PIX_READY <= (count_d < CW'(DEPTH));
    end
  end

  assign O_VSYNC = sb_q.vsync;
  assign O_HSYNC = sb_q.hsync;
  assign O_DE    = sb_q.de;

`ifdef VIDEO_PAD_PARITY_EN
  always_ff @(posedge I_CORE_CLK or posedge I_RST) begin
    if (I_RST) O_PAD_PARITY <= 1'b0;
    else       O_PAD_PARITY <= (state_d == SHIFT) ? ~^pad_d : 1'b0;
  end
`endif

endmodule
